// File: rtl/my_pc_ctrl.sv
// Program-counter controller for the 16-bit fetch path: valid/ready fetch
// request, jump/call/return redirects and a small return-address stack.

// Increment in library bit order (bit 15 = LSB); wraps FFFF -> 0000.
module my_inc16 (
  input  logic [15:0] a_i,
  output logic [15:0] y_o
);
  logic [15:0] a_num_s;
  logic [15:0] y_num_s;

  for (genvar i = 0; i < 16; i++) begin : g_rev
    assign a_num_s[i] = a_i[15-i];
    assign y_o[i]     = y_num_s[15-i];
  end

  assign y_num_s = a_num_s + 16'd1;
endmodule

module my_pc_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic        call,
  input  logic [15:0] call_addr,
  input  logic        ret,
  output logic [15:0] pc,
  output logic        pc_valid,
  input  logic        pc_ready,
  output logic [3:0]  sp,
  output logic        fault
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [3:0]    sp_q, sp_d;
  logic          pc_valid_q, pc_valid_d;
  logic          fault_q, fault_d;
  logic [15:0]   stack_q [DEPTH];
  logic          push_s;
  logic [15:0]   inc_s;
  logic [AW-1:0] top_idx_s;
  logic [AW-1:0] push_idx_s;

  // RESET_VEC is an arithmetic value; the PC register holds library bit order.
  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  my_inc16 u_inc (
    .a_i (pc_q),
    .y_o (inc_s)
  );

  assign top_idx_s  = AW'(sp_q - 4'd1);
  assign push_idx_s = AW'(sp_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      pc_q       <= rev16(RESET_VEC);
      sp_q       <= 4'd0;
      pc_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      pc_valid_q <= pc_valid_d;
      fault_q    <= fault_d;
      if (push_s) stack_q[push_idx_s] <= inc_s;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push_s  = 1'b0;
    case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (ret) begin
          if (sp_q == 4'd0) begin
            state_d = FAULT;
          end else begin
            pc_d = stack_q[top_idx_s];
            sp_d = sp_q - 4'd1;
          end
        end else if (call) begin
          if (sp_q == 4'(DEPTH)) begin
            state_d = FAULT;
          end else begin
            push_s = 1'b1;
            sp_d   = sp_q + 4'd1;
            pc_d   = call_addr;
          end
        end else if (load) begin
          pc_d = load_addr;
        end else if (pc_ready) begin
          pc_d = inc_s;
        end else begin
          pc_d = pc_q;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    pc_valid_d = (state_d == RUN);
    fault_d    = fault_q | (state_d == FAULT);
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign sp       = sp_q;
  assign fault    = fault_q;
endmodule

// File: tb/tb_my_pc_ctrl.sv
// Directed bench for my_pc_ctrl; addresses are written as arithmetic values
// and converted to/from library bit order (bit 15 = LSB) at the ports.
module tb_my_pc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, load, call, ret, pc_ready;
  logic [15:0] load_addr, call_addr, pc;
  logic        pc_valid, fault;
  logic [3:0]  sp;
  int          checks = 0;
  int          errors = 0;

  my_pc_ctrl #(.DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_addr(load_addr),
    .call(call), .call_addr(call_addr), .ret(ret), .pc(pc),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .sp(sp), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] exp_pc,
                           input logic [3:0] exp_sp, input logic exp_v, input logic exp_f);
    check_eq({tag, ".pc"},    rev16(pc),        exp_pc);
    check_eq({tag, ".sp"},    {12'h000, sp},    {12'h000, exp_sp});
    check_eq({tag, ".valid"}, {15'h0, pc_valid}, {15'h0, exp_v});
    check_eq({tag, ".fault"}, {15'h0, fault},    {15'h0, exp_f});
  endtask

  task automatic clr_cmds();
    load = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_ready = 1'b1; clr_cmds();
    load_addr = 16'h0000; call_addr = 16'h0000;
    tick(); tick();
    chk_state("reset", 16'h0000, 4'd0, 1'b0, 1'b0);

    // reset then stream
    rst_n = 1'b1;
    chk_state("init1", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick(); chk_state("run0", 16'h0000, 4'd0, 1'b1, 1'b0);
    tick(); chk_state("run1", 16'h0001, 4'd0, 1'b1, 1'b0);
    tick(); chk_state("run2", 16'h0002, 4'd0, 1'b1, 1'b0);
    tick(); chk_state("run3", 16'h0003, 4'd0, 1'b1, 1'b0);

    // stall and wrap
    load = 1'b1; load_addr = rev16(16'hFFFE);
    tick(); check_eq("wrap.load", rev16(pc), 16'hFFFE);
    load = 1'b0; pc_ready = 1'b1;
    tick(); check_eq("wrap.adv", rev16(pc), 16'hFFFF);
    pc_ready = 1'b0;
    tick(); check_eq("wrap.stall", rev16(pc), 16'hFFFF);
    pc_ready = 1'b1;
    tick(); check_eq("wrap.zero", rev16(pc), 16'h0000);

    // call / return
    pc_ready = 1'b0; load = 1'b1; load_addr = rev16(16'h0010);
    tick(); check_eq("cr.load", rev16(pc), 16'h0010);
    load = 1'b0; call = 1'b1; call_addr = rev16(16'h0200);
    tick(); chk_state("cr.call", 16'h0200, 4'd1, 1'b1, 1'b0);
    call = 1'b0; pc_ready = 1'b1;
    tick(); check_eq("cr.adv1", rev16(pc), 16'h0201);
    tick(); check_eq("cr.adv2", rev16(pc), 16'h0202);
    ret = 1'b1;
    tick(); chk_state("cr.ret", 16'h0011, 4'd0, 1'b1, 1'b0);

    // priority: ret beats call and load
    ret = 1'b0; pc_ready = 1'b0; load = 1'b1; load_addr = rev16(16'h0041);
    tick(); load = 1'b0; call = 1'b1; call_addr = rev16(16'h0300);
    tick(); chk_state("pri.setup", 16'h0300, 4'd1, 1'b1, 1'b0);
    ret = 1'b1; call = 1'b1; load = 1'b1;
    call_addr = rev16(16'h0500); load_addr = rev16(16'h0600);
    tick(); chk_state("pri.ret", 16'h0042, 4'd0, 1'b1, 1'b0);

    // overflow with five nested calls
    clr_cmds(); call = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      call_addr = rev16(16'(k * 16'h1000));
      tick(); chk_state($sformatf("ovf.call%0d", k), 16'(k * 16'h1000), 4'(k), 1'b1, 1'b0);
    end
    call_addr = rev16(16'h5000);
    tick(); chk_state("ovf.fault", 16'h4000, 4'd4, 1'b0, 1'b1);
    call = 1'b0; load = 1'b1; load_addr = rev16(16'h7777); pc_ready = 1'b1;
    tick(); chk_state("ovf.ign_load", 16'h4000, 4'd4, 1'b0, 1'b1);
    load = 1'b0; ret = 1'b1;
    tick(); chk_state("ovf.ign_ret", 16'h4000, 4'd4, 1'b0, 1'b1);

    // reset out of FAULT; a command during INIT is ignored
    clr_cmds(); rst_n = 1'b0;
    tick(); chk_state("rst1", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1; load = 1'b1; load_addr = rev16(16'h1234);
    tick(); chk_state("rst1.run", 16'h0000, 4'd0, 1'b1, 1'b0);

    // underflow and recovery
    load = 1'b0; pc_ready = 1'b0; ret = 1'b1;
    tick(); chk_state("udf.fault", 16'h0000, 4'd0, 1'b0, 1'b1);
    ret = 1'b0; rst_n = 1'b0;
    tick(); chk_state("udf.rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk_state("udf.init", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick(); chk_state("udf.run", 16'h0000, 4'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
